block_transmit_sd: RTL and testbench
====================================

# block_transmit_sd

Block-write data engine for the SPI-mode SD interface. It streams one 512-byte data block from the 256×16 cache to the card, bit-serial on SDout, framed as gap, start token, data and CRC16. It then captures the card's data-response token and waits out card busy. It is the transmit counterpart of the block-read path and runs on the same 400 kHz bit clock, launched by the command sequencer after a CMD24 response.

## Interface
Parameters:
- RESP_WAIT, 16: max SDin-high cycles after CRC before response timeout.
- BUSY_MAX, 65535: max SDin-low busy cycles before busy timeout.

Ports:
- clk400  in  1  bit clock; all state on rising edge.
- reset  in  1  asynchronous, active-low; low forces idle state immediately.
- enable  in  1  start request; sampled only in IDLE.
- SDin  in  1  card data-out line (MISO).
- SDout  out  1  card data-in line (MOSI); reset 1.
- casheAddress  out  8  cache word address; reset 0.
- readCashe  out  1  one-cycle cache read strobe; reset 0.
- casheValue  in  16  cache read data; valid the cycle after readCashe.
- busy  out  1  high from enable acceptance until done; reset 0.
- done  out  1  one-cycle pulse at end of transfer; reset 0.
- status  out  3  response status bits sss; held until next start; reset 0.
- error  out  1  high with done unless status==3'b010 and no timeout; held; reset 0.

## Operation
States: IDLE → GAP → TOKEN → DATA → CRC → RESP → STAT → BUSYW → FIN → IDLE.
- IDLE: SDout=1, busy=0. enable=1 → GAP. Enable also clears status/error and CRC register, and sets casheAddress=0.
- GAP: 8 bits of 1.
- TOKEN: 8 bits 0xFE, MSB first. readCashe pulses with casheAddress=0 during token bit 1. Word 0 latched into the shift register on the next cycle.
- DATA: 256 words × 16 bits, MSB first, byte order as stored (bit 15 first).
  - While bit 8 of word k is on the line, readCashe pulses with casheAddress=k+1, for k<255.
  - casheValue is captured the following cycle into a holding register and loaded at the word boundary.
  - No read is issued for k=255. casheAddress stays 255.
- CRC: CRC16-CCITT, poly x^16+x^12+x^5+1, init 0x0000. Computed over the 4096 data bits only. Sent as 16 bits, MSB first.
- RESP: SDout=1. Waits for SDin=0, which is the token's 0 bit.
  - If RESP_WAIT cycles pass with SDin=1: status=3'b111, error=1, go to FIN.
- STAT: shift in the next 3 SDin bits into status, then sample 1 more bit, which is ignored.
- BUSYW: wait for SDin=1.
  - More than BUSY_MAX cycles low: error=1, go to FIN.
  - status is kept.
- FIN: done=1 for one cycle, busy drops the same cycle. Then IDLE.

Boundary rules:
- enable while busy is ignored, with no restart.
- enable held high across FIN starts a new transfer from IDLE, one cycle after FIN.
- reset low at any point, including mid-word or mid-busy: all outputs go to reset values asynchronously. The transfer is abandoned and no done pulse is produced.
- Counters: 3-bit bit counter in GAP/TOKEN/STAT, 4-bit in-word counter, 8-bit word counter, 16-bit wait counter. No wrap is ever reachable in legal operation.

## Timing
- Cycle 0 = edge on which enable is sampled in IDLE. SDout carries GAP bit 0 after that edge.
- SDout changes only on rising clk400 edges, one bit per cycle.
- Bit counts: GAP 8, TOKEN 8, DATA 4096, CRC 16, for 4128 transmit cycles total.
- First data bit appears 16 cycles after acceptance. Last CRC bit appears at cycle 4127.
- RESP begins at cycle 4128.
- done appears ≥ 4 + 1 cycles after the response start bit is seen, plus busy duration.
- Cache contract: exactly 256 readCashe pulses per transfer, addresses 0..255 in order, each 16 cycles apart after the first.

## Test plan
- All-zero cache, card returns 0xE5 then SDin=1 → SDout carries 0xFF, 0xFE, 4096 zeros, CRC 0x0000. status=3'b010, error=0, single done pulse.
- Cache all 0xFFFF, token 0xE5, busy low 100 cycles → CRC sent 0x7FA1. done exactly 100 cycles after the token's last bit plus FIN. error=0.
- Cache word k = {k, ~k} → readCashe addresses 0..255 in order, 16 cycles apart. Serialized data matches byte-for-byte.
- Card returns 0xEB (CRC error) → status=3'b101, error=1, done pulses.
- SDin held 1 after CRC → after 16 cycles status=3'b111, error=1, done.
- reset low at data word 37 bit 5 → SDout=1, busy=0, readCashe=0 immediately. No done. Fresh enable completes a normal transfer.

Source files
------------

// File: rtl/block_transmit_sd.sv
// block_transmit_sd: SPI-mode SD single-block write engine on the 400 kHz bit clock.
// Serializes gap, start token, 256 cache words and CRC16, then collects the data response and waits out card busy.
module block_transmit_sd #(
  parameter int unsigned RESP_WAIT = 16,
  parameter int unsigned BUSY_MAX  = 65535
) (
  input  logic        clk400,
  input  logic        reset,
  input  logic        enable,
  input  logic        SDin,
  output logic        SDout,
  output logic [7:0]  casheAddress,
  output logic        readCashe,
  input  logic [15:0] casheValue,
  output logic        busy,
  output logic        done,
  output logic [2:0]  status,
  output logic        error
);

  localparam int unsigned WORD_W  = 16;
  localparam int unsigned WAIT_W  = 16;
  localparam logic [7:0]  START_TOKEN = 8'hFE;
  localparam logic [15:0] CRC_POLY    = 16'h1021;
  localparam logic [2:0]  STAT_OK     = 3'b010;
  localparam logic [2:0]  STAT_TMO    = 3'b111;
  localparam logic [7:0]  LAST_WORD   = 8'd255;

  typedef enum logic [3:0] {
    S_IDLE,
    S_GAP,
    S_TOKEN,
    S_DATA,
    S_CRC,
    S_RESP,
    S_STAT,
    S_BUSYW,
    S_FIN
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [2:0]          r_bit3, w_bit3_nxt;
  logic [3:0]          r_bit4, w_bit4_nxt;
  logic [7:0]          r_word, w_word_nxt;
  logic [WAIT_W-1:0]   r_wait, w_wait_nxt;
  logic [WORD_W-1:0]   r_shift, w_shift_nxt;
  logic [WORD_W-1:0]   r_hold, w_hold_nxt;
  logic                r_rd_q;
  logic [15:0]         r_crc, w_crc_nxt, w_crc_step;
  logic                r_sdout, w_sdout_nxt;
  logic [7:0]          r_addr, w_addr_nxt;
  logic                r_rd, w_rd_nxt;
  logic                r_busy, w_busy_nxt;
  logic                r_done, w_done_nxt;
  logic [2:0]          r_status, w_status_nxt;
  logic                r_error, w_error_nxt;
  logic [2:0]          w_tok_idx;

  // One bit of CRC16-CCITT (x^16+x^12+x^5+1), MSB-first feed.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
    logic fb;
    fb = crc[15] ^ din;
    return {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
  endfunction

  assign w_crc_step = crc16_step(r_crc, r_sdout);
  assign w_tok_idx  = 3'd6 - r_bit3;

  assign SDout        = r_sdout;
  assign casheAddress = r_addr;
  assign readCashe    = r_rd;
  assign busy         = r_busy;
  assign done         = r_done;
  assign status       = r_status;
  assign error        = r_error;

  always_ff @(posedge clk400 or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_bit3   <= 3'd0;
      r_bit4   <= 4'd0;
      r_word   <= 8'd0;
      r_wait   <= '0;
      r_shift  <= '0;
      r_hold   <= '0;
      r_rd_q   <= 1'b0;
      r_crc    <= 16'h0000;
      r_sdout  <= 1'b1;
      r_addr   <= 8'd0;
      r_rd     <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_status <= 3'b000;
      r_error  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_bit3   <= w_bit3_nxt;
      r_bit4   <= w_bit4_nxt;
      r_word   <= w_word_nxt;
      r_wait   <= w_wait_nxt;
      r_shift  <= w_shift_nxt;
      r_hold   <= w_hold_nxt;
      r_rd_q   <= r_rd;
      r_crc    <= w_crc_nxt;
      r_sdout  <= w_sdout_nxt;
      r_addr   <= w_addr_nxt;
      r_rd     <= w_rd_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_status <= w_status_nxt;
      r_error  <= w_error_nxt;
    end
  end

  // Next-state and next-output logic; the registered SDout always carries the bit for the coming cycle.
  always_comb begin
    w_state_nxt  = r_state;
    w_bit3_nxt   = r_bit3;
    w_bit4_nxt   = r_bit4;
    w_word_nxt   = r_word;
    w_wait_nxt   = r_wait;
    w_shift_nxt  = r_shift;
    w_hold_nxt   = r_rd_q ? casheValue : r_hold;
    w_crc_nxt    = r_crc;
    w_sdout_nxt  = r_sdout;
    w_addr_nxt   = r_addr;
    w_rd_nxt     = 1'b0;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;
    w_status_nxt = r_status;
    w_error_nxt  = r_error;

    case (r_state)
      S_IDLE: begin
        w_sdout_nxt = 1'b1;
        w_busy_nxt  = 1'b0;
        if (enable) begin
          w_state_nxt  = S_GAP;
          w_busy_nxt   = 1'b1;
          w_bit3_nxt   = 3'd0;
          w_status_nxt = 3'b000;
          w_error_nxt  = 1'b0;
          w_crc_nxt    = 16'h0000;
          w_addr_nxt   = 8'd0;
        end
      end

      S_GAP: begin
        if (r_bit3 == 3'd7) begin
          w_state_nxt = S_TOKEN;
          w_bit3_nxt  = 3'd0;
          w_sdout_nxt = START_TOKEN[7];
        end else begin
          w_bit3_nxt  = r_bit3 + 3'd1;
          w_sdout_nxt = 1'b1;
        end
      end

      // Word 0 is fetched during token bit 1 so it is held before the first data bit.
      S_TOKEN: begin
        w_rd_nxt = (r_bit3 == 3'd0);
        if (r_bit3 == 3'd7) begin
          w_state_nxt = S_DATA;
          w_bit4_nxt  = 4'd0;
          w_word_nxt  = 8'd0;
          w_shift_nxt = r_hold;
          w_sdout_nxt = r_hold[15];
        end else begin
          w_bit3_nxt  = r_bit3 + 3'd1;
          w_sdout_nxt = START_TOKEN[w_tok_idx];
        end
      end

      S_DATA: begin
        w_crc_nxt = w_crc_step;
        if (r_bit4 == 4'd6 && r_word != LAST_WORD) begin
          w_rd_nxt   = 1'b1;
          w_addr_nxt = 8'(r_word + 8'd1);
        end
        if (r_bit4 == 4'd15) begin
          w_bit4_nxt = 4'd0;
          if (r_word == LAST_WORD) begin
            w_state_nxt = S_CRC;
            w_sdout_nxt = w_crc_step[15];
          end else begin
            w_word_nxt  = 8'(r_word + 8'd1);
            w_shift_nxt = r_hold;
            w_sdout_nxt = r_hold[15];
          end
        end else begin
          w_bit4_nxt  = r_bit4 + 4'd1;
          w_shift_nxt = {r_shift[14:0], 1'b0};
          w_sdout_nxt = r_shift[14];
        end
      end

      // The CRC register doubles as the output shifter once data is complete.
      S_CRC: begin
        if (r_bit4 == 4'd15) begin
          w_state_nxt = S_RESP;
          w_wait_nxt  = '0;
          w_sdout_nxt = 1'b1;
        end else begin
          w_bit4_nxt  = r_bit4 + 4'd1;
          w_crc_nxt   = {r_crc[14:0], 1'b0};
          w_sdout_nxt = r_crc[14];
        end
      end

      S_RESP: begin
        w_sdout_nxt = 1'b1;
        if (!SDin) begin
          w_state_nxt = S_STAT;
          w_bit3_nxt  = 3'd0;
        end else if (r_wait == WAIT_W'(RESP_WAIT - 1)) begin
          w_state_nxt  = S_FIN;
          w_status_nxt = STAT_TMO;
          w_error_nxt  = 1'b1;
          w_done_nxt   = 1'b1;
          w_busy_nxt   = 1'b0;
        end else begin
          w_wait_nxt = r_wait + WAIT_W'(1);
        end
      end

      S_STAT: begin
        w_sdout_nxt = 1'b1;
        if (r_bit3 == 3'd3) begin
          w_state_nxt = S_BUSYW;
          w_wait_nxt  = '0;
        end else begin
          w_status_nxt = {r_status[1:0], SDin};
          w_bit3_nxt   = r_bit3 + 3'd1;
        end
      end

      S_BUSYW: begin
        w_sdout_nxt = 1'b1;
        if (SDin) begin
          w_state_nxt = S_FIN;
          w_error_nxt = (r_status != STAT_OK);
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
        end else if (r_wait == WAIT_W'(BUSY_MAX)) begin
          w_state_nxt = S_FIN;
          w_error_nxt = 1'b1;
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
        end else begin
          w_wait_nxt = r_wait + WAIT_W'(1);
        end
      end

      S_FIN: begin
        w_state_nxt = S_IDLE;
        w_sdout_nxt = 1'b1;
        w_busy_nxt  = 1'b0;
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_sdout_nxt = 1'b1;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_block_transmit_sd.sv
// Scoreboard bench for block_transmit_sd: a card/cache model drives the DUT, a monitor checks the serial stream,
// cache fetches and completion against expectations derived from the block contents and card behaviour.
module tb_block_transmit_sd;

  localparam int RESP_WAIT = 16;
  localparam int BUSY_MAX  = 300;
  localparam int TX_BITS   = 4128;
  localparam int BUDGET    = 6000;

  logic        clk400 = 1'b0;
  logic        reset;
  logic        enable;
  logic        SDin = 1'b1;
  logic        SDout;
  logic [7:0]  casheAddress;
  logic        readCashe;
  logic [15:0] casheValue = 16'h0000;
  logic        busy;
  logic        done;
  logic [2:0]  status;
  logic        error;

  always #5 clk400 = ~clk400;

  block_transmit_sd #(.RESP_WAIT(RESP_WAIT), .BUSY_MAX(BUSY_MAX)) dut (
    .clk400(clk400), .reset(reset), .enable(enable), .SDin(SDin), .SDout(SDout),
    .casheAddress(casheAddress), .readCashe(readCashe), .casheValue(casheValue),
    .busy(busy), .done(done), .status(status), .error(error)
  );

  typedef struct { logic [7:0] addr; int cyc; } rd_t;
  typedef struct { logic [2:0] st; logic err; int cyc; } done_t;

  logic [15:0] mem [256];
  logic [7:0]  exp_bytes [$];
  rd_t         exp_rd [$];
  done_t       exp_done [$];

  int          total, bad, done_cnt;
  int          card_r, card_l;
  logic [7:0]  card_tok;
  logic [15:0] exp_crc;
  logic [2:0]  last_st;
  logic        last_err;

  // Registered cache: data valid the cycle after the read strobe.
  always @(posedge clk400) if (readCashe) casheValue <= mem[casheAddress];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] crc_byte(input logic [15:0] c_in, input logic [7:0] d);
    logic [15:0] c;
    c = c_in ^ {d, 8'h00};
    for (int i = 0; i < 8; i++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    return c;
  endfunction

  // Card line: idle high, token framed so its start bit lands at cycle card_r, then card_l busy-low cycles.
  function automatic logic card_bit(input int e);
    if (card_r < 0) return 1'b1;
    if (e >= card_r - 3 && e <= card_r + 4) return card_tok[3'(7 - (e - card_r + 3))];
    if (e > card_r + 4 && e <= card_r + 4 + card_l) return 1'b0;
    return 1'b1;
  endfunction

  int   c_rel = 0;
  logic c_busy_q = 1'b0;
  always @(negedge clk400) begin
    if (busy && !c_busy_q) c_rel = 0;
    else c_rel++;
    c_busy_q = busy;
    SDin = card_bit(c_rel + 1);
  end

  task automatic expect_xfer();
    logic [15:0] crc;
    rd_t   r;
    done_t d;
    int    bl;
    crc = 16'h0000;
    exp_bytes.push_back(8'hFF);
    exp_bytes.push_back(8'hFE);
    for (int k = 0; k < 256; k++) begin
      exp_bytes.push_back(mem[k][15:8]);
      exp_bytes.push_back(mem[k][7:0]);
      crc = crc_byte(crc, mem[k][15:8]);
      crc = crc_byte(crc, mem[k][7:0]);
    end
    exp_bytes.push_back(crc[15:8]);
    exp_bytes.push_back(crc[7:0]);
    exp_crc = crc;
    for (int a = 0; a < 256; a++) begin
      r.addr = 8'(a);
      r.cyc  = (a == 0) ? 9 : 16 * a + 7;
      exp_rd.push_back(r);
    end
    if (card_r >= 0 && card_r <= TX_BITS + RESP_WAIT) begin
      d.st  = card_tok[3:1];
      bl    = (card_l > BUSY_MAX) ? BUSY_MAX : card_l;
      d.err = (d.st != 3'b010) || (card_l > BUSY_MAX);
      d.cyc = card_r + 5 + bl;
    end else begin
      d.st  = 3'b111;
      d.err = 1'b1;
      d.cyc = TX_BITS + RESP_WAIT;
    end
    exp_done.push_back(d);
    last_st  = d.st;
    last_err = d.err;
  endtask

  // Monitor: relative cycle counted from the busy rising edge.
  int         m_rel = 0, m_nbits = 0;
  logic       m_busy_q = 1'b0;
  logic [7:0] m_byte = 8'h00;
  logic [7:0] m_eb;
  rd_t        m_r;
  done_t      m_d;
  always @(negedge clk400) begin
    if (!reset) begin
      m_busy_q = 1'b0;
      m_nbits  = 0;
      m_rel    = 0;
    end else begin
      if (busy && !m_busy_q) m_rel = 0;
      else m_rel++;
      m_busy_q = busy;
      if (busy && m_rel < TX_BITS) begin
        m_byte = {m_byte[6:0], SDout};
        m_nbits++;
        if (m_nbits == 8) begin
          m_nbits = 0;
          check("byte_avail", int'(exp_bytes.size() != 0), 1);
          if (exp_bytes.size() != 0) begin
            m_eb = exp_bytes.pop_front();
            check("tx_byte", int'(m_byte), int'(m_eb));
          end
        end
      end
      if (readCashe) begin
        check("rd_avail", int'(exp_rd.size() != 0), 1);
        if (exp_rd.size() != 0) begin
          m_r = exp_rd.pop_front();
          check("rd_addr", int'(casheAddress), int'(m_r.addr));
          check("rd_cycle", m_rel, m_r.cyc);
        end
      end
      if (done) begin
        done_cnt++;
        check("done_avail", int'(exp_done.size() != 0), 1);
        if (exp_done.size() != 0) begin
          m_d = exp_done.pop_front();
          check("status", int'(status), int'(m_d.st));
          check("error", int'(error), int'(m_d.err));
          check("done_cycle", m_rel, m_d.cyc);
          check("busy_at_done", int'(busy), 0);
        end
      end
    end
  end

  task automatic start_xfer();
    expect_xfer();
    @(negedge clk400);
    enable = 1'b1;
    @(negedge clk400);
    enable = 1'b0;
  endtask

  task automatic wait_done();
    int c;
    c = 0;
    while (done !== 1'b1 && c < BUDGET) begin
      @(negedge clk400);
      c++;
    end
    check("done_seen", int'(done), 1);
  endtask

  task automatic post_checks();
    repeat (2) @(negedge clk400);
    check("done_single", int'(done), 0);
    check("bytes_left", exp_bytes.size(), 0);
    check("reads_left", exp_rd.size(), 0);
    check("dones_left", exp_done.size(), 0);
    check("status_held", int'(status), int'(last_st));
    check("error_held", int'(error), int'(last_err));
  endtask

  task automatic run_one(input int r, input logic [7:0] tok, input int l);
    card_r = r; card_tok = tok; card_l = l;
    start_xfer();
    wait_done();
    post_checks();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int dc0;
    total = 0; bad = 0; done_cnt = 0;
    card_r = -1; card_tok = 8'hE5; card_l = 0;
    reset = 1'b0; enable = 1'b0;
    #12;
    check("rst_sdout", int'(SDout), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_rd", int'(readCashe), 0);
    check("rst_addr", int'(casheAddress), 0);
    check("rst_status", int'(status), 0);
    check("rst_error", int'(error), 0);
    @(negedge clk400);
    reset = 1'b1;
    repeat (3) @(negedge clk400);

    for (int k = 0; k < 256; k++) mem[k] = 16'h0000;
    run_one(TX_BITS + 3, 8'hE5, 0);

    for (int k = 0; k < 256; k++) mem[k] = 16'hFFFF;
    run_one(TX_BITS + 2, 8'hE5, 100);
    check("crc_ones_model", int'(exp_crc), 32'h7FA1);

    for (int k = 0; k < 256; k++) mem[k] = {8'(k), ~8'(k)};
    run_one(TX_BITS + 1, 8'hE5, int'($urandom_range(0, 40)));

    for (int k = 0; k < 256; k++) mem[k] = 16'($urandom);
    run_one(TX_BITS + 7, 8'hEB, 5);
    run_one(-1, 8'hE5, 0);
    run_one(TX_BITS + RESP_WAIT, 8'hE5, BUSY_MAX);
    run_one(TX_BITS + 4, 8'hE5, BUSY_MAX + 10);

    // Abort mid-word: reset lands while word 37 bit 5 is on the line.
    for (int k = 0; k < 256; k++) mem[k] = 16'($urandom);
    card_r = TX_BITS + 2; card_tok = 8'hE5; card_l = 3;
    start_xfer();
    repeat (613) @(posedge clk400);
    #2;
    check("pre_abort_bit", int'(SDout), int'(mem[37][10]));
    reset = 1'b0;
    exp_bytes.delete(); exp_rd.delete(); exp_done.delete();
    dc0 = done_cnt;
    #1;
    check("abort_sdout", int'(SDout), 1);
    check("abort_busy", int'(busy), 0);
    check("abort_rd", int'(readCashe), 0);
    check("abort_addr", int'(casheAddress), 0);
    check("abort_done", int'(done), 0);
    repeat (3) @(negedge clk400);
    reset = 1'b1;
    repeat (40) @(negedge clk400);
    check("no_done_after_abort", done_cnt, dc0);
    for (int k = 0; k < 256; k++) mem[k] = 16'($urandom);
    run_one(TX_BITS + 5, 8'hE5, int'($urandom_range(0, 20)));

    // Enable held high: no restart while busy, new transfer two cycles after done.
    for (int k = 0; k < 256; k++) mem[k] = 16'($urandom);
    card_r = TX_BITS + 2; card_tok = 8'hE5; card_l = 7;
    expect_xfer();
    expect_xfer();
    @(negedge clk400);
    enable = 1'b1;
    wait_done();
    check("b2b_busy_fin", int'(busy), 0);
    @(negedge clk400);
    check("b2b_busy_idle", int'(busy), 0);
    @(negedge clk400);
    check("b2b_restart", int'(busy), 1);
    enable = 1'b0;
    wait_done();
    post_checks();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
